// File: rtl/opnd_fetch_ctrl_if.sv
// Bundle, memory-read and execute links of the operand fetch controller.
// master = the controller, slave = the surrounding decode/memory/execute logic.
interface opnd_fetch_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_opnd0_is_mem;
    logic        in_opnd1_is_mem;
    logic        in_addr_16bit;
    logic [1:0]  in_opnd_count;
    logic [31:0] in_opnd0_r;
    logic [31:0] in_opnd1_r;
    logic [31:0] in_opnd2_r;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_opnd_count;
    logic [31:0] out_opnd0;
    logic [31:0] out_opnd1;
    logic [31:0] out_opnd2;

    logic        busy;
    logic        fault;

    modport master (
        input  in_valid, in_opnd0_is_mem, in_opnd1_is_mem, in_addr_16bit,
               in_opnd_count, in_opnd0_r, in_opnd1_r, in_opnd2_r,
               mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output in_ready, mem_req_valid, mem_req_addr, out_valid,
               out_opnd_count, out_opnd0, out_opnd1, out_opnd2, busy, fault
    );

    modport slave (
        output in_valid, in_opnd0_is_mem, in_opnd1_is_mem, in_addr_16bit,
               in_opnd_count, in_opnd0_r, in_opnd1_r, in_opnd2_r,
               mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  in_ready, mem_req_valid, mem_req_addr, out_valid,
               out_opnd_count, out_opnd0, out_opnd1, out_opnd2, busy, fault
    );
endinterface

// File: rtl/opnd_fetch_ctrl.sv
// Operand fetch sequencer: reads memory-form operands, then hands the bundle to execute.
// Optional WAIT-state timeout is enabled with `define OPND_FETCH_TIMEOUT_EN.
module opnd_fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    opnd_fetch_ctrl_if.master  bus
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_e;

    if (2**CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e      state_q, state_d;
    logic        mem0_q, mem0_d;
    logic        mem1_q, mem1_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] opnd0_q, opnd0_d;
    logic [31:0] opnd1_q, opnd1_d;
    logic [31:0] opnd2_q, opnd2_d;
    logic        timeout_w;

    function automatic logic [31:0] resolve_in(input logic [31:0] v, input logic is_mem,
                                               input logic a16);
        return (is_mem && a16) ? {16'h0, v[15:0]} : v;
    endfunction

`ifdef OPND_FETCH_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    // Held at zero while requesting, so every WAIT entry starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (state_q == REQ0 || state_q == REQ1)
            cnt_q <= '0;
        else if (state_q == WAIT0 || state_q == WAIT1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign timeout_w = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_w = 1'b0;
`endif

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d           = state_q;
        mem0_d            = mem0_q;
        mem1_d            = mem1_q;
        count_d           = count_q;
        opnd0_d           = opnd0_q;
        opnd1_d           = opnd1_q;
        opnd2_d           = opnd2_q;
        bus.in_ready      = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = 32'h0;
        bus.out_valid     = 1'b0;
        bus.fault         = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    mem0_d  = bus.in_opnd0_is_mem;
                    mem1_d  = bus.in_opnd1_is_mem;
                    count_d = bus.in_opnd_count;
                    opnd0_d = resolve_in(bus.in_opnd0_r, bus.in_opnd0_is_mem, bus.in_addr_16bit);
                    opnd1_d = resolve_in(bus.in_opnd1_r, bus.in_opnd1_is_mem, bus.in_addr_16bit);
                    opnd2_d = bus.in_opnd2_r;
                    if (bus.in_opnd0_is_mem)      state_d = REQ0;
                    else if (bus.in_opnd1_is_mem) state_d = REQ1;
                    else                          state_d = DONE;
                end
            end
            REQ0: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = opnd0_q;
                if (bus.mem_req_ready) state_d = WAIT0;
            end
            WAIT0: begin
                if (bus.mem_rsp_valid) begin
                    opnd0_d = bus.mem_rsp_data;
                    state_d = mem1_q ? REQ1 : DONE;
                end else if (timeout_w) begin
                    bus.fault = 1'b1;
                    state_d   = IDLE;
                end
            end
            REQ1: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = opnd1_q;
                if (bus.mem_req_ready) state_d = WAIT1;
            end
            WAIT1: begin
                if (bus.mem_rsp_valid) begin
                    opnd1_d = bus.mem_rsp_data;
                    state_d = DONE;
                end else if (timeout_w) begin
                    bus.fault = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand registers are reset too, because out_* must read 0 after reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mem0_q  <= 1'b0;
            mem1_q  <= 1'b0;
            count_q <= 2'd0;
            opnd0_q <= 32'h0;
            opnd1_q <= 32'h0;
            opnd2_q <= 32'h0;
        end else begin
            state_q <= state_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
            opnd0_q <= opnd0_d;
            opnd1_q <= opnd1_d;
            opnd2_q <= opnd2_d;
        end
    end

    assign bus.out_opnd_count = count_q;
    assign bus.out_opnd0      = opnd0_q;
    assign bus.out_opnd1      = opnd1_q;
    assign bus.out_opnd2      = opnd2_q;
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_opnd_fetch_ctrl.sv
// Directed bench for opnd_fetch_ctrl; the timeout case runs only with OPND_FETCH_TIMEOUT_EN.
module tb_opnd_fetch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    opnd_fetch_ctrl_if bus ();

`ifdef OPND_FETCH_TIMEOUT_EN
    opnd_fetch_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    opnd_fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic m0, input logic m1, input logic a16, input logic [1:0] cnt,
                        input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2);
        bus.in_valid        = 1'b1;
        bus.in_opnd0_is_mem = m0;
        bus.in_opnd1_is_mem = m1;
        bus.in_addr_16bit   = a16;
        bus.in_opnd_count   = cnt;
        bus.in_opnd0_r      = o0;
        bus.in_opnd1_r      = o1;
        bus.in_opnd2_r      = o2;
        #1;
        chk("capture_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.in_valid        = 1'b0;
        bus.in_opnd0_is_mem = 1'b0;
        bus.in_opnd1_is_mem = 1'b0;
        bus.in_addr_16bit   = 1'b0;
        bus.in_opnd_count   = 2'd0;
        bus.in_opnd0_r      = 32'h0;
        bus.in_opnd1_r      = 32'h0;
        bus.in_opnd2_r      = 32'h0;
        bus.mem_req_ready   = 1'b1;
        bus.mem_rsp_valid   = 1'b0;
        bus.mem_rsp_data    = 32'h0;
        bus.out_ready       = 1'b1;
        tick();
        tick();

        chk("rst_busy",      32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_req_addr",  bus.mem_req_addr, 32'h0);
        chk("rst_opnd0",     bus.out_opnd0, 32'h0);
        chk("rst_fault",     32'(bus.fault), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: register-only bundle completes one cycle after capture
        send(1'b0, 1'b0, 1'b0, 2'd3, 32'h11, 32'h22, 32'h33);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_opnd0",     bus.out_opnd0, 32'h11);
        chk("t1_opnd1",     bus.out_opnd1, 32'h22);
        chk("t1_opnd2",     bus.out_opnd2, 32'h33);
        chk("t1_count",     32'(bus.out_opnd_count), 32'd3);
        chk("t1_no_req",    32'(bus.mem_req_valid), 32'd0);
        chk("t1_in_ready",  32'(bus.in_ready), 32'd0);
        tick();
        chk("t1_idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_idle_in_ready",  32'(bus.in_ready), 32'd1);

        // 2: opnd0 from memory, opnd1 passes through
        send(1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h55, 32'h66);
        chk("t2_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("t2_req_addr",  bus.mem_req_addr, 32'h0000_1000);
        tick();
        chk("t2_req_drop",  32'(bus.mem_req_valid), 32'd0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_opnd0",     bus.out_opnd0, 32'hDEAD_BEEF);
        chk("t2_opnd1",     bus.out_opnd1, 32'h55);
        tick();

        // 3: 16-bit address mask applies to the memory operand only
        send(1'b0, 1'b1, 1'b1, 2'd2, 32'hFFFF_0077, 32'hABCD_1234, 32'h0);
        chk("t3_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("t3_req_addr",  bus.mem_req_addr, 32'h0000_1234);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1234_ABCD;
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_opnd0",     bus.out_opnd0, 32'hFFFF_0077);
        chk("t3_opnd1",     bus.out_opnd1, 32'h1234_ABCD);
        tick();

        // 4: request and output backpressure, two memory operands
        bus.mem_req_ready = 1'b0;
        bus.out_ready     = 1'b0;
        send(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'h0000_3000, 32'h77);
        for (int i = 0; i < 3; i++) begin
            chk("t4_req0_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("t4_req0_addr",  bus.mem_req_addr, 32'h0000_2000);
            chk("t4_in_ready",   32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        #1;
        chk("t4_req0_addr_acc", bus.mem_req_addr, 32'h0000_2000);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hA0A0_0000;
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("t4_req1_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("t4_req1_addr",  bus.mem_req_addr, 32'h0000_3000);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hA1A1_1111;
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_opnd0",     bus.out_opnd0, 32'hA0A0_0000);
            chk("t4_opnd1",     bus.out_opnd1, 32'hA1A1_1111);
            chk("t4_opnd2",     bus.out_opnd2, 32'h77);
            chk("t4_hold_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4_out_valid_hs", 32'(bus.out_valid), 32'd1);
        tick();
        chk("t4_in_ready_after", 32'(bus.in_ready), 32'd1);

        // 5: async reset in WAIT0, late response ignored, next bundle correct
        send(1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_4000, 32'h0, 32'h0);
        tick();
        chk("t5_busy_wait", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy",  32'(bus.busy), 32'd0);
        chk("t5_rst_req",   32'(bus.mem_req_valid), 32'd0);
        chk("t5_rst_opnd0", bus.out_opnd0, 32'h0);
        tick();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("t5_late_busy",  32'(bus.busy), 32'd0);
        chk("t5_late_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_late_opnd0", bus.out_opnd0, 32'h0);
        send(1'b0, 1'b0, 1'b0, 2'd1, 32'h99, 32'h0, 32'h0);
        chk("t5_next_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_next_opnd0", bus.out_opnd0, 32'h99);
        tick();

`ifdef OPND_FETCH_TIMEOUT_EN
        // 6: no response; fault on the fifth WAIT0 cycle (count reaches 4)
        send(1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_5000, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_fault", 32'(bus.fault), 32'd0);
            tick();
        end
        chk("t6_fault",       32'(bus.fault), 32'd1);
        chk("t6_no_out",      32'(bus.out_valid), 32'd0);
        tick();
        chk("t6_fault_clear", 32'(bus.fault), 32'd0);
        chk("t6_in_ready",    32'(bus.in_ready), 32'd1);
        chk("t6_out_valid",   32'(bus.out_valid), 32'd0);
`else
        chk("fault_tied", 32'(bus.fault), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
